matrix_result_writer: RTL and testbench

//  Downstream stage of the matrix processor. Collects 4-lane result vectors (one per work item)

---
 rtl/mp_pkg.sv | 14 +
 rtl/mp_result_fifo.sv | 61 ++++++
 rtl/matrix_result_writer.sv | 153 +++++++++++++++
 tb/tb_matrix_result_writer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared definitions for the matrix processor result path: lane count,
// default datapath word width and the result-writer FSM encoding.
package mp_pkg;

    localparam int LANES          = 4;
    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } writer_state_t;

endpackage

// File: rtl/mp_result_fifo.sv
// Small synchronous FIFO of result vectors. Exposes the head and the entry
// behind it so the consumer can look one pop ahead.
module mp_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       headData,
    output logic [WIDTH-1:0]       secondData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdPtrInc;
    logic [CNT_W-1:0] countReg;
    logic             pushEn;
    logic             popEn;

    assign pushEn   = push && !full;
    assign popEn    = pop && !empty;
    assign rdPtrInc = rdPtr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtrInc;
            end
            countReg <= countReg + CNT_W'(pushEn) - CNT_W'(popEn);
        end
    end

    assign headData   = mem[rdPtr];
    assign secondData = mem[rdPtrInc];
    assign full       = (countReg == CNT_W'(DEPTH));
    assign empty      = (countReg == '0);
    assign count      = countReg;

endmodule

// File: rtl/matrix_result_writer.sv
// Collects 4-lane result vectors into a FIFO and serialises them as
// single-word memory writes at base + item*4 + lane, then pulses done.
module matrix_result_writer
    import mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       baseAddr,
    input  logic [CNT_W-1:0]        itemCount,
    input  logic                    resultValid,
    input  logic [LANES*DATA_W-1:0] resultData,
    output logic                    resultReady,
    output logic                    memWrReq,
    output logic [ADDR_W-1:0]       memAddr,
    output logic [DATA_W-1:0]       memData,
    input  logic                    memAck,
    output logic                    busy,
    output logic                    done
);
    localparam int VEC_W  = LANES * DATA_W;
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    writer_state_t     stateReg;
    writer_state_t     stateNext;
    logic [ADDR_W-1:0] baseReg;
    logic [ADDR_W-1:0] baseNext;
    logic [ADDR_W-1:0] addrNext;
    logic [CNT_W-1:0]  countReg;
    logic [CNT_W-1:0]  acceptCnt;
    logic [CNT_W-1:0]  itemIdx;
    logic [CNT_W-1:0]  itemNext;
    logic [1:0]        laneIdx;
    logic [1:0]        laneNext;
    logic [VEC_W-1:0]  fifoHead;
    logic [VEC_W-1:0]  fifoSecond;
    logic [VEC_W-1:0]  headNext;
    logic [FCNT_W-1:0] fifoCount;
    logic [FCNT_W-1:0] fifoCountNext;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              startFire;
    logic              pushFire;
    logic              ackFire;
    logic              popFire;
    logic              lastAck;
    logic [DATA_W-1:0] headLanes [LANES];

    assign startFire   = start && (stateReg == IDLE);
    assign resultReady = (stateReg == RUN) && !fifoFull && (acceptCnt < countReg);
    assign pushFire    = resultValid && resultReady;
    assign ackFire     = memWrReq && memAck;
    assign popFire     = ackFire && (laneIdx == 2'd3);
    assign lastAck     = popFire && (itemIdx == countReg - CNT_W'(1));

    mp_result_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (pushFire),
        .pushData   (resultData),
        .pop        (popFire),
        .headData   (fifoHead),
        .secondData (fifoSecond),
        .full       (fifoFull),
        .empty      (fifoEmpty),
        .count      (fifoCount)
    );

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = (itemCount == '0) ? FINISH : RUN;
            RUN:     if (lastAck) stateNext = FINISH;
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        laneNext = laneIdx;
        itemNext = itemIdx;
        if (startFire) begin
            laneNext = '0;
            itemNext = '0;
        end else if (ackFire) begin
            if (laneIdx == 2'd3) begin
                laneNext = '0;
                itemNext = itemIdx + CNT_W'(1);
            end else begin
                laneNext = laneIdx + 2'd1;
            end
        end
    end

    // Outputs are registered, so compute what the FIFO head will be after
    // this edge; an empty FIFO being pushed forwards the incoming vector.
    always_comb begin
        if (popFire) begin
            headNext = (fifoCount >= FCNT_W'(2)) ? fifoSecond : resultData;
        end else begin
            headNext = fifoEmpty ? resultData : fifoHead;
        end
    end

    assign fifoCountNext = fifoCount + FCNT_W'(pushFire) - FCNT_W'(popFire);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign headLanes[gi] = headNext[gi*DATA_W +: DATA_W];
    end

    assign baseNext = startFire ? baseAddr : baseReg;
    assign addrNext = baseNext + ADDR_W'({itemNext, 2'b00}) + ADDR_W'(laneNext);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            baseReg   <= '0;
            countReg  <= '0;
            acceptCnt <= '0;
            itemIdx   <= '0;
            laneIdx   <= '0;
            memWrReq  <= 1'b0;
            memAddr   <= '0;
            memData   <= '0;
        end else begin
            stateReg <= stateNext;
            baseReg  <= baseNext;
            itemIdx  <= itemNext;
            laneIdx  <= laneNext;
            if (startFire) begin
                countReg  <= itemCount;
                acceptCnt <= '0;
            end else if (pushFire) begin
                acceptCnt <= acceptCnt + CNT_W'(1);
            end
            memWrReq <= (stateNext == RUN) && (fifoCountNext != '0);
            memAddr  <= addrNext;
            memData  <= headLanes[laneNext];
        end
    end

    assign busy = (stateReg != IDLE);
    assign done = (stateReg == FINISH);

endmodule

// File: tb/tb_matrix_result_writer.sv
// Scenario bench for matrix_result_writer: directed jobs plus randomized
// valid/ack traffic checked against an address/data list built from accepted vectors.
module tb_matrix_result_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] baseAddr;
    logic [7:0]  itemCount;
    logic        resultValid;
    logic [63:0] resultData;
    logic        resultReady;
    logic        memWrReq;
    logic [15:0] memAddr;
    logic [15:0] memData;
    logic        memAck;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    matrix_result_writer #(
        .DATA_W (16),
        .ADDR_W (16),
        .CNT_W  (8),
        .DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .baseAddr    (baseAddr),
        .itemCount   (itemCount),
        .resultValid (resultValid),
        .resultData  (resultData),
        .resultReady (resultReady),
        .memWrReq    (memWrReq),
        .memAddr     (memAddr),
        .memData     (memData),
        .memAck      (memAck),
        .busy        (busy),
        .done        (done)
    );

    int checks = 0;
    int errors = 0;

    int          obsAddr[$];
    int          obsData[$];
    int          obsCyc[$];
    logic [63:0] accVec[$];
    int          accCyc[$];
    logic [63:0] fixedVec[$];
    int          expAddr[$];
    int          expData[$];
    int          doneCnt;
    int          doneCyc;
    int          busyCyc;
    int          holdViol;
    int          accAtRelease;
    logic        readyAtRelease;

    // Every accepted vector i produces lanes 0..3 at base + 4*i + lane (mod 64K).
    function automatic void build_model(input int base);
        logic [63:0] v;
        expAddr.delete();
        expData.delete();
        foreach (accVec[i]) begin
            v = accVec[i];
            for (int l = 0; l < 4; l++) begin
                expAddr.push_back((base + i * 4 + l) % 65536);
                expData.push_back(int'(v[l*16 +: 16]));
            end
        end
    endfunction

    function automatic int write_mismatches();
        int n = 0;
        if (obsAddr.size() != expAddr.size()) return -1;
        foreach (obsAddr[i]) begin
            if (obsAddr[i] != expAddr[i] || obsData[i] != expData[i]) n++;
        end
        return n;
    endfunction

    task automatic run_job(input logic [15:0] base, input logic [7:0] cnt, input int validPct,
                           input int ackPct, input int ackOffCycles, input int restartAt,
                           input int maxCycles);
        bit          offering = 0;
        bit          holdPend = 0;
        logic [15:0] holdA = '0;
        logic [15:0] holdD = '0;
        int          cyc = 0;
        int          tail = 0;
        obsAddr.delete(); obsData.delete(); obsCyc.delete();
        accVec.delete(); accCyc.delete();
        doneCnt = 0; doneCyc = -1; busyCyc = 0; holdViol = 0;
        accAtRelease = -1; readyAtRelease = 1'bx;
        start = 1'b1; baseAddr = base; itemCount = cnt; resultValid = 1'b0; memAck = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < maxCycles && !(doneCnt > 0 && tail >= 3)) begin
            start = (cyc == restartAt);
            if (start) begin
                baseAddr  = base ^ 16'h5A5A;
                itemCount = cnt + 8'd3;
            end
            if (!offering) begin
                offering = ($urandom_range(99) < validPct);
                if (fixedVec.size() > 0) resultData = fixedVec.pop_front();
                else resultData = {$urandom, $urandom};
            end
            resultValid = offering;
            memAck = (cyc >= ackOffCycles) && ($urandom_range(99) < ackPct);
            #1;
            if (holdPend && (!memWrReq || memAddr !== holdA || memData !== holdD)) holdViol++;
            holdPend = memWrReq && !memAck;
            holdA = memAddr;
            holdD = memData;
            if (resultValid && resultReady) begin
                accVec.push_back(resultData);
                accCyc.push_back(cyc);
                offering = 1'b0;
            end
            if (cyc == ackOffCycles - 1) begin
                accAtRelease   = accVec.size();
                readyAtRelease = resultReady;
            end
            if (memWrReq && memAck) begin
                obsAddr.push_back(int'(memAddr));
                obsData.push_back(int'(memData));
                obsCyc.push_back(cyc);
            end
            if (busy) busyCyc++;
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (doneCnt > 0) tail++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; resultValid = 1'b0; memAck = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; baseAddr = '0; itemCount = '0;
        resultValid = 1'b1; resultData = 64'hDEAD_BEEF_1234_5678; memAck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({resultReady, memWrReq, memAddr, memData, busy, done} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {resultReady, memWrReq, memAddr, memData, busy, done});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resultReady !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_not_ready: ready=%b busy=%b expected 0 0", resultReady, busy);
        end
        resultValid = 1'b0;
        $display("test_reset: outputs checked in and after reset");
    endtask

    task automatic test_basic();
        fixedVec.delete();
        fixedVec.push_back(64'h0004_0003_0002_0001);
        fixedVec.push_back(64'h0008_0007_0006_0005);
        run_job(16'h0100, 8'd2, 100, 100, 0, -1, 60);
        checks++;
        if (obsAddr.size() != 8) begin
            errors++;
            $display("FAIL basic_write_count: got %0d expected 8", obsAddr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obsAddr[i] != 'h100 + i || obsData[i] != i + 1) begin
                    errors++;
                    $display("FAIL basic_write%0d: got (%h,%h) expected (%h,%h)", i, obsAddr[i], obsData[i], 'h100 + i, i + 1);
                end
            end
            checks++;
            if (obsCyc[0] != accCyc[0] + 1 || obsCyc[7] != obsCyc[0] + 7 || doneCyc != obsCyc[7] + 1) begin
                errors++;
                $display("FAIL basic_timing: accept=%0d first=%0d last=%0d done=%0d expected first=accept+1 last=first+7 done=last+1",
                         accCyc[0], obsCyc[0], obsCyc[7], doneCyc);
            end
        end
        checks++;
        if (doneCnt != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d expected 1", doneCnt);
        end
        $display("test_basic: %0d writes, done at cycle %0d", obsAddr.size(), doneCyc);
    endtask

    task automatic test_zero_count();
        run_job(16'h0040, 8'd0, 100, 100, 0, -1, 40);
        checks++;
        if (doneCyc != 0 || doneCnt != 1 || busyCyc != 1) begin
            errors++;
            $display("FAIL zero_count_done: doneCyc=%0d doneCnt=%0d busyCyc=%0d expected 0 1 1", doneCyc, doneCnt, busyCyc);
        end
        checks++;
        if (obsAddr.size() != 0 || accVec.size() != 0) begin
            errors++;
            $display("FAIL zero_count_traffic: writes=%0d accepted=%0d expected 0 0", obsAddr.size(), accVec.size());
        end
        $display("test_zero_count: done at cycle %0d, busy %0d cycles", doneCyc, busyCyc);
    endtask

    task automatic test_backpressure();
        run_job(16'h0300, 8'd6, 100, 100, 10, -1, 200);
        checks++;
        if (accAtRelease != 4 || readyAtRelease !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_stall: accepted=%0d ready=%b expected 4 0", accAtRelease, readyAtRelease);
        end
        checks++;
        if (holdViol != 0) begin
            errors++;
            $display("FAIL bp_hold_stable: got %0d violations expected 0", holdViol);
        end
        build_model(16'h0300);
        checks++;
        if (obsAddr.size() != 24 || accVec.size() != 6 || write_mismatches() != 0) begin
            errors++;
            $display("FAIL bp_writes: writes=%0d accepted=%0d mismatches=%0d expected 24 6 0",
                     obsAddr.size(), accVec.size(), write_mismatches());
        end
        $display("test_backpressure: %0d accepted before release, %0d writes", accAtRelease, obsAddr.size());
    endtask

    task automatic test_wrap();
        run_job(16'hFFFE, 8'd1, 100, 100, 0, -1, 40);
        build_model(16'hFFFE);
        checks++;
        if (obsAddr.size() != 4 || obsAddr[0] != 'hFFFE || obsAddr[1] != 'hFFFF
            || obsAddr[2] != 'h0000 || obsAddr[3] != 'h0001 || write_mismatches() != 0) begin
            errors++;
            $display("FAIL wrap_addresses: got %p expected FFFE FFFF 0000 0001", obsAddr);
        end
        $display("test_wrap: %0d writes", obsAddr.size());
    endtask

    task automatic test_reset_mid_job();
        int w = 0;
        int guard = 0;
        int doneSeen = 0;
        start = 1'b1; baseAddr = 16'h0500; itemCount = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        resultValid = 1'b1; resultData = {$urandom, $urandom}; memAck = 1'b1;
        while (w < 3 && guard < 50) begin
            #1;
            if (memWrReq && memAck) w++;
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (w != 3) begin
            errors++;
            $display("FAIL midreset_progress: got %0d writes expected 3", w);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({resultReady, memWrReq, memAddr, memData, busy, done} !== 36'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {resultReady, memWrReq, memAddr, memData, busy, done});
        end
        rst_n = 1'b1; resultValid = 1'b0; memAck = 1'b0;
        repeat (5) begin
            #1;
            if (done || busy || memWrReq) doneSeen++;
            @(posedge clk); #1;
        end
        checks++;
        if (doneSeen != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", doneSeen);
        end
        run_job(16'h0020, 8'd1, 100, 100, 0, -1, 40);
        build_model(16'h0020);
        checks++;
        if (obsAddr.size() != 4 || obsAddr[0] != 'h20 || obsAddr[3] != 'h23 || write_mismatches() != 0 || doneCnt != 1) begin
            errors++;
            $display("FAIL midreset_newjob: writes=%0d mismatches=%0d done=%0d expected 4 0 1",
                     obsAddr.size(), write_mismatches(), doneCnt);
        end
        $display("test_reset_mid_job: restart job wrote %0d words", obsAddr.size());
    endtask

    task automatic test_restart_ignored();
        run_job(16'h0700, 8'd2, 100, 100, 0, 3, 100);
        build_model(16'h0700);
        checks++;
        if (doneCnt != 1 || accVec.size() != 2 || obsAddr.size() != 8 || write_mismatches() != 0) begin
            errors++;
            $display("FAIL restart_ignored: done=%0d accepted=%0d writes=%0d mismatches=%0d expected 1 2 8 0",
                     doneCnt, accVec.size(), obsAddr.size(), write_mismatches());
        end
        $display("test_restart_ignored: %0d writes, %0d done pulses", obsAddr.size(), doneCnt);
    endtask

    task automatic test_random();
        logic [15:0] base;
        logic [7:0]  cnt;
        int          vp;
        int          ap;
        for (int j = 0; j < 8; j++) begin
            base = 16'($urandom);
            cnt  = 8'($urandom_range(9, 1));
            vp   = $urandom_range(100, 20);
            ap   = $urandom_range(100, 20);
            run_job(base, cnt, vp, ap, 0, -1, 2000);
            build_model(int'(base));
            checks++;
            if (doneCnt != 1 || accVec.size() != int'(cnt)) begin
                errors++;
                $display("FAIL random%0d_completion: done=%0d accepted=%0d expected 1 %0d", j, doneCnt, accVec.size(), cnt);
            end
            checks++;
            if (write_mismatches() != 0 || holdViol != 0) begin
                errors++;
                $display("FAIL random%0d_writes: mismatches=%0d holdViolations=%0d expected 0 0", j, write_mismatches(), holdViol);
            end
            checks++;
            if (obsCyc.size() == 0 || doneCyc != obsCyc[obsCyc.size()-1] + 1) begin
                errors++;
                $display("FAIL random%0d_done_timing: done=%0d expected last write cycle + 1", j, doneCyc);
            end
            $display("test_random job %0d: base=%h count=%0d writes=%0d done=%0d", j, base, cnt, obsAddr.size(), doneCyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_wrap();
        test_reset_mid_job();
        test_restart_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
